id_exe_stage_reg: RTL and testbench
===================================

// Module: id_exe_stage_reg
// PURPOSE
// - ID->EXE pipeline register. Captures decoded control (s, b, mem_w_en, mem_r_en, wb_en, exe_cmd) plus operands/fields for EXE.
// - Applies condition-fail squash, hazard bubble, branch flush and global freeze in one place.
// - Keeps a saturating count of bubbles inserted, for profiling.
// PARAMETERS
// - DATA_W     32  width of pc, val_rn, val_rm
// - RADDR_W    4   register-file address width
// - BCNT_W     16  bubble counter width
// PORTS
// - clk             in   1        rising-edge clock
// - rst_n           in   1        asynchronous, active-low reset
// - freeze          in   1        global stall (e.g. memory wait); hold all state
// - flush           in   1        branch taken in EXE; squash instruction entering now
// - hazard          in   1        data hazard from ID; insert bubble
// - cond_pass       in   1        condition field of ID instruction satisfied
// - id_s/id_b/id_mem_w_en/id_mem_r_en/id_wb_en  in  1 each  decoded control
// - id_exe_cmd      in   4        ALU command (don't-care when id_b=1)
// - id_pc,id_val_rn,id_val_rm  in  DATA_W  PC+4 and operands
// - id_imm          in   1        immediate operand select
// - id_shift_op     in   12       shifter operand field
// - id_simm24       in   24       signed branch offset
// - id_dest         in   RADDR_W  destination register
// - id_carry        in   1        C flag from status register
// - ex_* (same set as id_*, plus ex_valid)  out  registered copies
// - bubble_cnt      out  BCNT_W   saturating bubble count
// BEHAVIOUR
// - Reset (rst_n=0, async): all ex_* = 0, ex_valid=0, bubble_cnt=0. Effect immediate, no clock needed.
// - Priority per rising edge: freeze > flush > hazard > load.
// - freeze=1: every register holds, bubble_cnt holds; other inputs ignored.
// - flush=1 (freeze=0): control bits (s,b,mem_w_en,mem_r_en,wb_en) = 0, exe_cmd = 0, ex_valid=0.
//   - Data fields still captured. Not counted as a bubble.
// - hazard=1 (no freeze/flush): same clearing as flush.
//   - bubble_cnt += 1, saturating at all-ones.
// - load (none of the above): all fields captured. ex_valid=1.
//   - If cond_pass=0, the five control bits are forced to 0 and exe_cmd=0.
//   - The condition-failed instruction still has ex_valid=1 (occupies a slot, no architectural effect).
// - Latency: exactly one cycle from id_* to ex_* when loading.
// - exe_cmd captured verbatim; an X input with id_b=1 passes through. Downstream must not use exe_cmd when ex_b=1.
// - Simultaneous flush+hazard: flush wins, no count. freeze+anything: hold.
// - bubble_cnt wraps never; stays at 2^BCNT_W-1 once reached.
// - Deassertion of rst_n mid-stream: first edge after release behaves as a normal edge per priority.
// STRUCTURE
// - Shared package: exe_cmd encodings (MOV=1, ADD=2, ADC=3, SUB=4, SBC=5, AND=6, ORR=7, EOR=8, MVN=9, NOP=0).
//   - The package also holds the control-bundle struct (s,b,mem_w_en,mem_r_en,wb_en,exe_cmd) and DATA_W/RADDR_W defaults.
// - One sub-module: pipe_reg_en_clr (generic width, async-low reset, enable, sync clear).
//   - Instantiated once for the control bundle and once for the data bundle.
// - Bubble counter inline.
// TESTING
// - Reset: drive inputs nonzero, pulse rst_n low between edges -> all ex_* and bubble_cnt read 0 immediately.
// - Load ADD: exe_cmd=2, wb_en=1, val_rn=5, val_rm=7, cond_pass=1 -> next edge ex_exe_cmd=2, ex_wb_en=1, ex_val_rn=5, ex_valid=1.
// - Cond fail: LDR (mem_r_en=1, wb_en=1, exe_cmd=2), cond_pass=0 -> ex_mem_r_en=0, ex_wb_en=0, ex_exe_cmd=0, ex_valid=1.
// - Hazard x3, then flush+hazard together -> bubble_cnt=3; on the flush edge ex_valid=0 and the count stays 3.
// - Freeze: load STR (mem_w_en=1), then freeze=1 for 4 cycles with changing inputs -> ex_* stay unchanged, bubble_cnt unchanged.
// - Saturation: BCNT_W=2, hazard for 5 cycles -> bubble_cnt sticks at 3.

Source files
------------

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared definitions for the ID->EXE pipeline register: ALU command encodings,
// the decoded control bundle and default datapath widths.
package id_exe_stage_reg_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 4;
  localparam int EXE_CMD_W   = 4;

  typedef enum logic [EXE_CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_MOV = 4'd1,
    CMD_ADD = 4'd2,
    CMD_ADC = 4'd3,
    CMD_SUB = 4'd4,
    CMD_SBC = 4'd5,
    CMD_AND = 4'd6,
    CMD_ORR = 4'd7,
    CMD_EOR = 4'd8,
    CMD_MVN = 4'd9
  } exe_cmd_e;

  // exe_cmd is plain logic so an undefined command on a branch passes through untouched
  typedef struct packed {
    logic                 s;
    logic                 b;
    logic                 mem_w_en;
    logic                 mem_r_en;
    logic                 wb_en;
    logic [EXE_CMD_W-1:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{s: 1'b0, b: 1'b0, mem_w_en: 1'b0, mem_r_en: 1'b0,
                                 wb_en: 1'b0, exe_cmd: CMD_NOP};

endpackage

// File: rtl/id_exe_stage_reg_pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset, load enable, synchronous clear.
// Clear only takes effect when enabled, so a stall always wins over a squash.
module pipe_reg_en_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (en)  q <= clr ? '0 : d;
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze/flush/hazard/condition squash handling
// and a saturating bubble counter for profiling.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int BCNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 hazard,
  input  logic                 cond_pass,
  input  logic                 id_s,
  input  logic                 id_b,
  input  logic                 id_mem_w_en,
  input  logic                 id_mem_r_en,
  input  logic                 id_wb_en,
  input  logic [EXE_CMD_W-1:0] id_exe_cmd,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic [DATA_W-1:0]    id_val_rn,
  input  logic [DATA_W-1:0]    id_val_rm,
  input  logic                 id_imm,
  input  logic [11:0]          id_shift_op,
  input  logic [23:0]          id_simm24,
  input  logic [RADDR_W-1:0]   id_dest,
  input  logic                 id_carry,
  output logic                 ex_valid,
  output logic                 ex_s,
  output logic                 ex_b,
  output logic                 ex_mem_w_en,
  output logic                 ex_mem_r_en,
  output logic                 ex_wb_en,
  output logic [EXE_CMD_W-1:0] ex_exe_cmd,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [DATA_W-1:0]    ex_val_rn,
  output logic [DATA_W-1:0]    ex_val_rm,
  output logic                 ex_imm,
  output logic [11:0]          ex_shift_op,
  output logic [23:0]          ex_simm24,
  output logic [RADDR_W-1:0]   ex_dest,
  output logic                 ex_carry,
  output logic [BCNT_W-1:0]    bubble_cnt
);

  localparam int CTRL_W = $bits(ctrl_t) + 1;
  localparam int DAT_W  = 3*DATA_W + 1 + 12 + 24 + RADDR_W + 1;

  ctrl_t             id_ctrl, ld_ctrl, ex_ctrl;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DAT_W-1:0]  dat_q;
  logic              squash;

  assign id_ctrl = '{s: id_s, b: id_b, mem_w_en: id_mem_w_en, mem_r_en: id_mem_r_en,
                     wb_en: id_wb_en, exe_cmd: id_exe_cmd};
  // A condition-failed instruction keeps its slot (valid) but loses all side effects
  assign ld_ctrl = cond_pass ? id_ctrl : CTRL_NOP;
  assign squash  = flush | hazard;

  pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!freeze),
    .clr   (squash),
    .d     ({1'b1, ld_ctrl}),
    .q     (ctrl_q)
  );

  // Operands are captured even on a squash; only the control path is cleared
  pipe_reg_en_clr #(.W(DAT_W)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!freeze),
    .clr   (1'b0),
    .d     ({id_pc, id_val_rn, id_val_rm, id_imm, id_shift_op, id_simm24, id_dest, id_carry}),
    .q     (dat_q)
  );

  assign {ex_valid, ex_ctrl} = ctrl_q;
  assign ex_s        = ex_ctrl.s;
  assign ex_b        = ex_ctrl.b;
  assign ex_mem_w_en = ex_ctrl.mem_w_en;
  assign ex_mem_r_en = ex_ctrl.mem_r_en;
  assign ex_wb_en    = ex_ctrl.wb_en;
  assign ex_exe_cmd  = ex_ctrl.exe_cmd;
  assign {ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_op, ex_simm24, ex_dest, ex_carry} = dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (!freeze && !flush && hazard && (bubble_cnt != {BCNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + BCNT_W'(1);
  end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios plus randomized
// traffic compared against a behavioural model of the pipeline slot.
module tb_id_exe_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze, flush, hazard, cond_pass;
  logic id_s, id_b, id_mem_w_en, id_mem_r_en, id_wb_en, id_imm, id_carry;
  logic [3:0]  id_exe_cmd;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [11:0] id_shift_op;
  logic [23:0] id_simm24;
  logic [3:0]  id_dest;

  logic ex_valid, ex_s, ex_b, ex_mem_w_en, ex_mem_r_en, ex_wb_en, ex_imm, ex_carry;
  logic [3:0]  ex_exe_cmd;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_simm24;
  logic [3:0]  ex_dest;
  logic [15:0] bubble_cnt;

  logic s2_valid, s2_s, s2_b, s2_mem_w_en, s2_mem_r_en, s2_wb_en, s2_imm, s2_carry;
  logic [3:0]  s2_exe_cmd;
  logic [31:0] s2_pc, s2_val_rn, s2_val_rm;
  logic [11:0] s2_shift_op;
  logic [23:0] s2_simm24;
  logic [3:0]  s2_dest;
  logic [1:0]  s2_bubble_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic m_valid, m_s, m_b, m_w, m_r, m_wb, m_imm, m_carry;
  logic [3:0]  m_cmd, m_dest;
  logic [31:0] m_pc, m_rn, m_rm;
  logic [11:0] m_sh;
  logic [23:0] m_simm;
  int m_cnt, m_cnt_sat;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
    .cond_pass(cond_pass), .id_s(id_s), .id_b(id_b), .id_mem_w_en(id_mem_w_en),
    .id_mem_r_en(id_mem_r_en), .id_wb_en(id_wb_en), .id_exe_cmd(id_exe_cmd),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_op(id_shift_op), .id_simm24(id_simm24), .id_dest(id_dest), .id_carry(id_carry),
    .ex_valid(ex_valid), .ex_s(ex_s), .ex_b(ex_b), .ex_mem_w_en(ex_mem_w_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_wb_en(ex_wb_en), .ex_exe_cmd(ex_exe_cmd),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm(ex_imm),
    .ex_shift_op(ex_shift_op), .ex_simm24(ex_simm24), .ex_dest(ex_dest), .ex_carry(ex_carry),
    .bubble_cnt(bubble_cnt)
  );

  id_exe_stage_reg #(.BCNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
    .cond_pass(cond_pass), .id_s(id_s), .id_b(id_b), .id_mem_w_en(id_mem_w_en),
    .id_mem_r_en(id_mem_r_en), .id_wb_en(id_wb_en), .id_exe_cmd(id_exe_cmd),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_op(id_shift_op), .id_simm24(id_simm24), .id_dest(id_dest), .id_carry(id_carry),
    .ex_valid(s2_valid), .ex_s(s2_s), .ex_b(s2_b), .ex_mem_w_en(s2_mem_w_en),
    .ex_mem_r_en(s2_mem_r_en), .ex_wb_en(s2_wb_en), .ex_exe_cmd(s2_exe_cmd),
    .ex_pc(s2_pc), .ex_val_rn(s2_val_rn), .ex_val_rm(s2_val_rm), .ex_imm(s2_imm),
    .ex_shift_op(s2_shift_op), .ex_simm24(s2_simm24), .ex_dest(s2_dest), .ex_carry(s2_carry),
    .bubble_cnt(s2_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_s, m_b, m_w, m_r, m_wb, m_imm, m_carry} = '0;
    m_cmd = '0; m_dest = '0; m_pc = '0; m_rn = '0; m_rm = '0; m_sh = '0; m_simm = '0;
    m_cnt = 0; m_cnt_sat = 0;
  endtask

  // One clock edge of the pipeline slot, evaluated from the priority rules
  task automatic model_edge();
    if (freeze) return;
    m_pc = id_pc; m_rn = id_val_rn; m_rm = id_val_rm; m_imm = id_imm;
    m_sh = id_shift_op; m_simm = id_simm24; m_dest = id_dest; m_carry = id_carry;
    if (flush || hazard) begin
      {m_valid, m_s, m_b, m_w, m_r, m_wb} = '0;
      m_cmd = 4'd0;
      if (!flush) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
    end else begin
      m_valid = 1'b1;
      if (cond_pass) begin
        m_s = id_s; m_b = id_b; m_w = id_mem_w_en; m_r = id_mem_r_en; m_wb = id_wb_en;
        m_cmd = id_exe_cmd;
      end else begin
        {m_s, m_b, m_w, m_r, m_wb} = '0;
        m_cmd = 4'd0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(m_valid));
    chk({tag, ".s"}, 64'(ex_s), 64'(m_s));
    chk({tag, ".b"}, 64'(ex_b), 64'(m_b));
    chk({tag, ".mem_w"}, 64'(ex_mem_w_en), 64'(m_w));
    chk({tag, ".mem_r"}, 64'(ex_mem_r_en), 64'(m_r));
    chk({tag, ".wb"}, 64'(ex_wb_en), 64'(m_wb));
    chk({tag, ".cmd"}, 64'(ex_exe_cmd), 64'(m_cmd));
    chk({tag, ".pc"}, 64'(ex_pc), 64'(m_pc));
    chk({tag, ".rn"}, 64'(ex_val_rn), 64'(m_rn));
    chk({tag, ".rm"}, 64'(ex_val_rm), 64'(m_rm));
    chk({tag, ".imm"}, 64'(ex_imm), 64'(m_imm));
    chk({tag, ".shift"}, 64'(ex_shift_op), 64'(m_sh));
    chk({tag, ".simm"}, 64'(ex_simm24), 64'(m_simm));
    chk({tag, ".dest"}, 64'(ex_dest), 64'(m_dest));
    chk({tag, ".carry"}, 64'(ex_carry), 64'(m_carry));
    chk({tag, ".cnt"}, 64'(bubble_cnt), 64'(m_cnt));
    chk({tag, ".cnt_sat"}, 64'(s2_bubble_cnt), 64'(m_cnt_sat));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    id_s = 1'($urandom); id_b = 1'($urandom); id_mem_w_en = 1'($urandom);
    id_mem_r_en = 1'($urandom); id_wb_en = 1'($urandom); id_imm = 1'($urandom);
    id_carry = 1'($urandom); id_exe_cmd = 4'($urandom_range(0, 9));
    id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_shift_op = 12'($urandom); id_simm24 = 24'($urandom); id_dest = 4'($urandom);
  endtask

  task automatic set_ctl(input logic fz, input logic fl, input logic hz, input logic cp);
    freeze = fz; flush = fl; hazard = hz; cond_pass = cp;
  endtask

  task automatic load_instr(input logic s, input logic b, input logic w, input logic r,
                            input logic wb, input logic [3:0] cmd);
    id_s = s; id_b = b; id_mem_w_en = w; id_mem_r_en = r; id_wb_en = wb; id_exe_cmd = cmd;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    #1 rst_n = 1'b1;
  endtask

  initial begin
    set_ctl(0, 0, 0, 1);
    rand_data();
    model_reset();
    #2;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // a few loads, then reset between edges with nonzero inputs
    repeat (3) begin rand_data(); step("pre"); end
    id_pc = 32'hFFFF_FFFF; id_val_rn = 32'h1234_5678;
    pulse_reset();

    // ADD loads with one-cycle latency
    set_ctl(0, 0, 0, 1);
    rand_data();
    load_instr(0, 0, 0, 0, 1, 4'd2);
    id_val_rn = 32'd5; id_val_rm = 32'd7;
    step("add");
    chk("add.cmd_abs", 64'(ex_exe_cmd), 64'd2);
    chk("add.rn_abs", 64'(ex_val_rn), 64'd5);

    // condition-failed LDR keeps its slot with no effect
    load_instr(0, 0, 0, 1, 1, 4'd2);
    set_ctl(0, 0, 0, 0);
    step("condfail");
    chk("condfail.valid_abs", 64'(ex_valid), 64'd1);

    // three bubbles, then flush+hazard: flush wins, no count
    pulse_reset();
    rand_data();
    set_ctl(0, 0, 1, 1);
    repeat (3) begin rand_data(); step("hazard"); end
    set_ctl(0, 1, 1, 1);
    rand_data();
    step("flush_hz");
    chk("flush_hz.cnt_abs", 64'(bubble_cnt), 64'd3);
    chk("flush_hz.valid_abs", 64'(ex_valid), 64'd0);

    // store, then freeze with changing inputs
    set_ctl(0, 0, 0, 1);
    rand_data();
    load_instr(0, 0, 1, 0, 0, 4'd2);
    step("str");
    for (int i = 0; i < 4; i++) begin
      rand_data();
      set_ctl(1, 1'($urandom), 1'($urandom), 1'($urandom));
      step("freeze");
    end
    chk("freeze.mem_w_abs", 64'(ex_mem_w_en), 64'd1);

    // saturation of the 2-bit counter instance
    set_ctl(0, 0, 1, 1);
    repeat (5) begin rand_data(); step("sat"); end
    chk("sat.cnt_abs", 64'(s2_bubble_cnt), 64'd3);

    // undefined exe_cmd on a branch passes through verbatim
    set_ctl(0, 0, 0, 1);
    rand_data();
    load_instr(0, 1, 0, 0, 0, 4'bxxxx);
    step("branch_x");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      set_ctl($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 80);
      if ($urandom_range(0, 99) < 2) pulse_reset();
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
